// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/exec/writeback sequencer.
// Ports: clk, rst_n, run, imem_* fetch port, instr, dec_regwrite, rf_we, pc, retired, halted, state.
module cpu_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   input  logic        dec_regwrite,
   output logic        rf_we,
   output logic [31:0] pc,
   output logic [31:0] retired,
   output logic        halted,
   output logic [2:0]  state
);

   localparam logic [31:0] STEP = 32'(PC_STEP);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } st_t;

   st_t  st;
   logic legal;
   logic wr_ok;

   always_comb begin
      legal = 1'b0;
      unique case (instr[6:0])
         7'h13, 7'h1B, 7'h17, 7'h37: legal = 1'b1;
         default:                    legal = 1'b0;
      endcase
   end

   // x0 is hardwired; never strobe a write to it
   assign wr_ok     = dec_regwrite & (instr[11:7] != 5'd0);
   assign imem_addr = pc;
   assign state     = st;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= IDLE;
         pc       <= RESET_PC;
         instr    <= 32'd0;
         retired  <= 32'd0;
         halted   <= 1'b0;
         imem_req <= 1'b0;
         rf_we    <= 1'b0;
      end else begin
         case (st)
            IDLE: begin
               rf_we <= 1'b0;
               if (run) begin
                  st       <= FETCH;
                  imem_req <= 1'b1;
               end
            end
            FETCH: begin
               if (imem_ready) begin
                  instr    <= imem_rdata;
                  imem_req <= 1'b0;
                  st       <= DECODE;
               end
            end
            DECODE: begin
               if (legal) begin
                  st <= EXEC;
               end else begin
                  st     <= TRAP;
                  halted <= 1'b1;
               end
            end
            EXEC: begin
               // strobe is registered so it is high for exactly the WB cycle
               st    <= WB;
               rf_we <= wr_ok;
            end
            WB: begin
               rf_we   <= 1'b0;
               pc      <= pc + STEP;
               retired <= retired + 32'd1;
               if (run) begin
                  st       <= FETCH;
                  imem_req <= 1'b1;
               end else begin
                  st <= IDLE;
               end
            end
            TRAP: begin
               halted   <= 1'b1;
               imem_req <= 1'b0;
               rf_we    <= 1'b0;
            end
            default: begin
               st       <= IDLE;
               imem_req <= 1'b0;
               rf_we    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed + randomized bench for cpu_sequencer.
// Uses a per-instruction reference model of pc, retired and strobes.
module tb_cpu_sequencer;

   localparam logic [31:0] RPC  = 32'hFFFF_FFFC;
   localparam int unsigned STEP = 4;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        dec_regwrite;
   logic        rf_we;
   logic [31:0] pc;
   logic [31:0] retired;
   logic        halted;
   logic [2:0]  state;

   int checks   = 0;
   int failures = 0;

   logic [31:0] pc_m;
   logic [31:0] ret_m;
   logic [31:0] instr_m;

   cpu_sequencer #(
      .RESET_PC (RPC),
      .PC_STEP  (STEP)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .run          (run),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .instr        (instr),
      .dec_regwrite (dec_regwrite),
      .rf_we        (rf_we),
      .pc           (pc),
      .retired      (retired),
      .halted       (halted),
      .state        (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic bit is_legal(input logic [31:0] w);
      return (w[6:0] == 7'h13) || (w[6:0] == 7'h1B) ||
             (w[6:0] == 7'h17) || (w[6:0] == 7'h37);
   endfunction

   task automatic model_reset();
      pc_m    = RPC;
      ret_m   = 32'd0;
      instr_m = 32'd0;
   endtask

   // Entered at a negedge with the DUT in FETCH. Runs one instruction.
   task automatic run_instr(input logic [31:0] word, input int w,
                            input bit rw, input bit run_after,
                            input bit rst_wb);
      logic exp_we;
      for (int i = 0; i <= w; i++) begin
         chk("fetch_state", 32'(state), 32'd1);
         chk("fetch_req", 32'(imem_req), 32'd1);
         chk("fetch_addr", imem_addr, pc_m);
         chk("instr_hold", instr, instr_m);
         imem_ready   = (i == w);
         imem_rdata   = (i == w) ? word : $urandom;
         dec_regwrite = rw;
         cyc();
      end
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      instr_m    = word;
      chk("instr_latch", instr, instr_m);
      chk("dec_state", 32'(state), 32'd2);
      chk("dec_req", 32'(imem_req), 32'd0);
      chk("dec_we", 32'(rf_we), 32'd0);
      if (!is_legal(word)) begin
         cyc();
         chk("trap_state", 32'(state), 32'd5);
         chk("trap_halted", 32'(halted), 32'd1);
         return;
      end
      cyc();
      chk("exec_state", 32'(state), 32'd3);
      chk("exec_we", 32'(rf_we), 32'd0);
      chk("exec_pc", pc, pc_m);
      run = run_after;
      cyc();
      exp_we = rw && (word[11:7] != 5'd0);
      chk("wb_state", 32'(state), 32'd4);
      chk("wb_we", 32'(rf_we), 32'(exp_we));
      chk("wb_pc", pc, pc_m);
      chk("wb_retired", retired, ret_m);
      if (rst_wb) begin
         #1 rst_n = 1'b0;
         #1;
         model_reset();
         chk("rstwb_we", 32'(rf_we), 32'd0);
         chk("rstwb_pc", pc, pc_m);
         chk("rstwb_ret", retired, ret_m);
         chk("rstwb_state", 32'(state), 32'd0);
         return;
      end
      cyc();
      pc_m  = pc_m + STEP;
      ret_m = ret_m + 32'd1;
      chk("post_pc", pc, pc_m);
      chk("post_ret", retired, ret_m);
      chk("post_we", 32'(rf_we), 32'd0);
      chk("post_state", 32'(state), run_after ? 32'd1 : 32'd0);
      chk("post_req", 32'(imem_req), 32'(run_after));
   endtask

   initial begin
      logic [6:0]  ops [4];
      logic [31:0] word;
      bit          ra;
      bit          idle;
      ops[0] = 7'h13;
      ops[1] = 7'h1B;
      ops[2] = 7'h17;
      ops[3] = 7'h37;

      rst_n        = 1'b0;
      run          = 1'b0;
      imem_ready   = 1'b0;
      imem_rdata   = 32'd0;
      dec_regwrite = 1'b0;
      model_reset();
      cyc();
      cyc();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_pc", pc, RPC);
      chk("rst_instr", instr, 32'd0);
      chk("rst_ret", retired, 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_we", 32'(rf_we), 32'd0);

      rst_n = 1'b1;
      cyc();
      cyc();
      chk("idle_hold", 32'(state), 32'd0);
      imem_ready = 1'b1;
      cyc();
      chk("idle_ready_ign", 32'(state), 32'd0);
      imem_ready = 1'b0;
      run = 1'b1;
      cyc();
      chk("first_fetch", 32'(state), 32'd1);

      // pc wraps FFFFFFFC -> 0, then 0 -> 4
      run_instr(32'h0050_0093, 0, 1'b1, 1'b1, 1'b0);
      chk("wrap_pc", pc, 32'h0000_0000);
      run_instr(32'h0050_0093, 0, 1'b1, 1'b1, 1'b0);
      // rd = x0: no write, still retires
      run_instr(32'h0000_0013, 3, 1'b1, 1'b1, 1'b0);
      chk("pc_at_8", pc, 32'h0000_0008);
      // illegal opcode at pc 8
      run_instr(32'h0000_0033, 1, 1'b1, 1'b1, 1'b0);
      imem_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("trap_halt", 32'(halted), 32'd1);
         chk("trap_pc", pc, 32'h0000_0008);
         chk("trap_ret", retired, 32'd3);
         chk("trap_req", 32'(imem_req), 32'd0);
      end
      imem_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      chk("trap_clr", 32'(halted), 32'd0);
      chk("trap_clr_pc", pc, RPC);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      chk("restart", 32'(state), 32'd1);

      // reset in the middle of writeback
      run_instr(32'h0010_0093, 0, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();

      idle = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (idle) begin
            run = 1'b0;
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
               cyc();
               chk("rand_idle", 32'(state), 32'd0);
            end
            run = 1'b1;
            cyc();
         end
         word = $urandom;
         word[6:0] = ops[$urandom_range(0, 3)];
         if ($urandom_range(0, 3) == 0) word[11:7] = 5'd0;
         ra = ($urandom_range(0, 3) != 0);
         run_instr(word, int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), ra, 1'b0);
         idle = !ra;
      end

      // reset while waiting in FETCH
      if (idle) begin
         run = 1'b1;
         cyc();
      end
      chk("pre_rst_fetch", 32'(state), 32'd1);
      imem_ready = 1'b0;
      cyc();
      chk("wait_req", 32'(imem_req), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rstf_req", 32'(imem_req), 32'd0);
      chk("rstf_pc", pc, RPC);
      chk("rstf_state", 32'(state), 32'd0);
      chk("rstf_ret", retired, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
